ldm_stm_seq: RTL and testbench
==============================

Name: ldm_stm_seq

Overview:
- Block-transfer sequencer for ARMv4 LDM/STM: iterates over a 16-bit register list and drives the register bank's index/latch ports.
- LDM: writes memory data into each listed register. STM: reads each listed register for store data.
- Generates word addresses, performs a req/ack memory handshake per word and optionally writes back the updated base.
- Sits between the decode/control unit and the register bank plus memory port; initiator side of the register-bank write/read interface.

Parameters:
- ADDR_W, 32, address and data width.
- WORD_BYTES, 4, address increment per transfer.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  launch transfer; sampled only in IDLE
- is_load  input  1  1=LDM, 0=STM
- up  input  1  U bit: 1=increment, 0=decrement
- pre  input  1  P bit: 1=before, 0=after
- wback  input  1  W bit: write back base
- base_idx  input  4  Rn index
- base_addr  input  32  Rn value at start
- reg_list  input  16  register list, bit i = Ri
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse at completion
- mem_req  output  1  memory request
- mem_we  output  1  1=store
- mem_addr  output  32  word address
- mem_wdata  output  32  store data (= reg_rdata)
- mem_ack  input  1  memory acknowledge, completes current word
- mem_rdata  input  32  load data, valid with mem_ack
- reg_ridx  output  4  register bank read index (STM)
- reg_rdata  input  32  register bank read data (combinational)
- reg_widx  output  4  register bank write index
- reg_wdata  output  32  register bank write data
- latch_reg  output  1  register bank write enable

Behaviour:
- Reset: state=IDLE. busy, done, mem_req, mem_we, latch_reg = 0. mem_addr, reg_widx, reg_ridx, reg_wdata = 0. Reset mid-transfer aborts immediately with no further writes.
- States: IDLE, XFER, WB, DONE.
- IDLE, start=1:
  - latch all inputs. n = popcount(reg_list).
  - start address: up&pre = base+4; up&!pre = base; !up&pre = base-4n; !up&!pre = base-4n+4.
  - final base: up ? base+4n : base-4n.
  - go to XFER; if n=0, go to DONE with no transfer and no writeback.
- Register order: lowest set index first, always at lowest address, regardless of up.
- XFER:
  - mem_req=1, mem_we=!is_load, mem_addr=current addr.
  - cur = index of lowest remaining set bit; reg_ridx = cur; mem_wdata = reg_rdata.
  - Outputs hold stable until mem_ack.
  - Cycle with mem_ack=1 and is_load: latch_reg=1, reg_widx=cur, reg_wdata=mem_rdata (combinational with ack).
  - On ack: clear bit cur; addr += 4 (mod 2^32). If no bits remain: go to WB if wback and not (is_load and base_idx set in the original list), else DONE. mem_req drops the cycle after the last ack.
- WB: one cycle, latch_reg=1, reg_widx=base_idx, reg_wdata=final base; then DONE.
- STM with base in list and wback: stores the original base value (read before WB).
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while not IDLE is ignored.
- Back-to-back operation: start may be accepted in the IDLE cycle immediately after DONE.
- Address arithmetic is 32-bit wrap-around; no alignment check, low 2 bits are passed through.

Test Plan:
- LDMIA r13!,{r0,r2}: base 0x8000, ack each word next cycle, rdata 0x11/0x22 -> addrs 0x8000, 0x8004; writes r0=0x11, r2=0x22; WB r13=0x8008; done one pulse.
- STMDB r13!,{r4,r14}: base 0x8000, r4=5, r14=0 -> addrs 0x7FF8 (wdata 5), 0x7FFC (wdata 0); WB r13=0x7FF8; mem_we=1 throughout.
- LDMIB r1,{r1,r3}, wback=1: base 0x100 -> addrs 0x104, 0x108; r1 gets loaded data; no WB cycle.
- Stalled ack: hold mem_ack=0 for 5 cycles on the 2nd word -> mem_addr and mem_req stable; exactly one latch_reg per word; busy stays high.
- Empty list plus start during busy: reg_list=0 -> done 1 cycle after start, no mem_req, no latch_reg. A second start mid-transfer is ignored.
- Reset mid-transfer: rst asserted during the 3rd word of a 4-register LDM -> next cycle IDLE, all outputs 0, no further latch_reg; a new start works normally.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: ARMv4 LDM/STM block-transfer sequencer.
// Walks a register list, issues one memory word per register, optional base writeback.
module ldm_stm_seq #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    input  logic [3:0]        base_idx,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic [3:0]        reg_ridx,
    input  logic [ADDR_W-1:0] reg_rdata,
    output logic [3:0]        reg_widx,
    output logic [ADDR_W-1:0] reg_wdata,
    output logic              latch_reg
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t            state;
    state_t            state_n;
    logic [15:0]       list_q;
    logic [15:0]       list_n;
    logic [15:0]       rem;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] fin_q;
    logic [ADDR_W-1:0] fin_n;
    logic [ADDR_W-1:0] span;
    logic              ld_q;
    logic              wb_q;
    logic              bin_q;
    logic [3:0]        bidx_q;
    logic [4:0]        cnt;
    logic [3:0]        cur;
    logic              accept;

    // Store data always comes straight from the register bank read port.
    assign mem_wdata = reg_rdata;

    // Number of listed registers and the byte span they cover.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0, reg_list[i]};
        end
        span = ADDR_W'(cnt) * STEP;
    end

    // Lowest remaining register is always the next one transferred.
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur = 4'(i);
            end
        end
        rem = list_q & ~(16'd1 << cur);
    end

    // State and transfer context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            list_q <= '0;
            addr_q <= '0;
            fin_q  <= '0;
            ld_q   <= 1'b0;
            wb_q   <= 1'b0;
            bin_q  <= 1'b0;
            bidx_q <= '0;
        end else begin
            state  <= state_n;
            list_q <= list_n;
            addr_q <= addr_n;
            fin_q  <= fin_n;
            if (accept) begin
                ld_q   <= is_load;
                wb_q   <= wback;
                bin_q  <= reg_list[base_idx];
                bidx_q <= base_idx;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n   = state;
        list_n    = list_q;
        addr_n    = addr_q;
        fin_n     = fin_q;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        reg_ridx  = '0;
        reg_widx  = '0;
        reg_wdata = '0;
        latch_reg = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    list_n = reg_list;
                    fin_n  = up ? base_addr + span : base_addr - span;
                    unique case ({up, pre})
                        2'b11:   addr_n = base_addr + STEP;
                        2'b10:   addr_n = base_addr;
                        2'b01:   addr_n = base_addr - span;
                        default: addr_n = base_addr - span + STEP;
                    endcase
                    state_n = (cnt == 5'd0) ? DONE : XFER;
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !ld_q;
                mem_addr = addr_q;
                reg_ridx = cur;
                if (mem_ack) begin
                    if (ld_q) begin
                        latch_reg = 1'b1;
                        reg_widx  = cur;
                        reg_wdata = mem_rdata;
                    end
                    list_n = rem;
                    addr_n = addr_q + STEP;
                    if (rem == 16'd0) begin
                        // A loaded base wins over the writeback value.
                        if (wb_q && !(ld_q && bin_q)) begin
                            state_n = WB;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
            end
            WB: begin
                busy      = 1'b1;
                latch_reg = 1'b1;
                reg_widx  = bidx_q;
                reg_wdata = fin_q;
                state_n   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset aborts at once: no write or request in the reset cycle.
        if (rst) begin
            latch_reg = 1'b0;
            mem_req   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: directed table-driven bench for the LDM/STM sequencer.
// Vectors carry hand-computed start address, final base and writeback flag.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        up;
    logic        pre;
    logic        wback;
    logic [3:0]  base_idx;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  reg_ridx;
    logic [31:0] reg_rdata;
    logic [3:0]  reg_widx;
    logic [31:0] reg_wdata;
    logic        latch_reg;

    logic [31:0] regs [16];
    int          checks = 0;
    int          errors = 0;
    int          latch_total = 0;

    typedef struct {
        logic        ld;
        logic        up;
        logic        pre;
        logic        wb;
        logic [3:0]  bidx;
        logic [31:0] base;
        logic [15:0] list;
        logic [31:0] a0;
        logic [31:0] fin;
        logic        do_wb;
    } vec_t;

    vec_t vecs [7];

    ldm_stm_seq #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_load   (is_load),
        .up        (up),
        .pre       (pre),
        .wback     (wback),
        .base_idx  (base_idx),
        .base_addr (base_addr),
        .reg_list  (reg_list),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .reg_ridx  (reg_ridx),
        .reg_rdata (reg_rdata),
        .reg_widx  (reg_widx),
        .reg_wdata (reg_wdata),
        .latch_reg (latch_reg)
    );

    always #5 clk = ~clk;

    assign reg_rdata = regs[reg_ridx];

    // Count register-bank writes as the bank would see them.
    always @(posedge clk) begin
        if (latch_reg === 1'b1) latch_total++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one transfer; optional stall on one word and a stray start.
    task automatic run_vec(input vec_t v, input int vi, input int stall_word,
                           input int stall_n);
        int          idx [16];
        int          n;
        int          l0;
        logic [31:0] ea;
        logic [31:0] rd;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.list[i]) begin
                idx[n] = i;
                n++;
            end
        end
        l0 = latch_total;
        start     = 1'b1;
        is_load   = v.ld;
        up        = v.up;
        pre       = v.pre;
        wback     = v.wb;
        base_idx  = v.bidx;
        base_addr = v.base;
        reg_list  = v.list;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            ea = v.a0 + 32'(4 * k);
            if (k == stall_word) begin
                for (int s = 0; s < stall_n; s++) begin
                    if (s == 0) begin
                        start    = 1'b1;
                        is_load  = ~v.ld;
                        reg_list = 16'hFFFF;
                    end
                    mem_ack = 1'b0;
                    #1;
                    chk("stall_req", 32'(mem_req), 32'd1);
                    chk("stall_addr", mem_addr, ea);
                    chk("stall_busy", 32'(busy), 32'd1);
                    chk("stall_latch", 32'(latch_reg), 32'd0);
                    tick();
                    start = 1'b0;
                end
            end
            rd = 32'h11 * 32'(k + 1) + 32'(vi << 8);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            #1;
            chk("req", 32'(mem_req), 32'd1);
            chk("we", 32'(mem_we), 32'(!v.ld));
            chk("addr", mem_addr, ea);
            chk("busy", 32'(busy), 32'd1);
            chk("ridx", 32'(reg_ridx), 32'(idx[k]));
            if (v.ld) begin
                chk("latch", 32'(latch_reg), 32'd1);
                chk("widx", 32'(reg_widx), 32'(idx[k]));
                chk("wdata", reg_wdata, rd);
            end else begin
                chk("st_latch", 32'(latch_reg), 32'd0);
                chk("st_wdata", mem_wdata, regs[idx[k]]);
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        #1;
        chk("req_drop", 32'(mem_req), 32'd0);
        if (v.do_wb) begin
            chk("wb_latch", 32'(latch_reg), 32'd1);
            chk("wb_idx", 32'(reg_widx), 32'(v.bidx));
            chk("wb_data", reg_wdata, v.fin);
            chk("wb_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_latch", 32'(latch_reg), 32'd0);
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("latch_cnt", 32'(latch_total - l0),
            32'((v.ld ? n : 0) + (v.do_wb ? 1 : 0)));
    endtask

    initial begin
        int l0;
        vec_t r4;
        // LDMIA r13!,{r0,r2}
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h8000, 16'h0005,
                    32'h8000, 32'h8008, 1'b1};
        // STMDB r13!,{r4,r14}
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h8000, 16'h4010,
                    32'h7FF8, 32'h7FF8, 1'b1};
        // LDMIB r1!,{r1,r3}: loaded base suppresses writeback
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0100, 16'h000A,
                    32'h0104, 32'h0108, 1'b0};
        // STMDA r0,{r0-r2}
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0200, 16'h0007,
                    32'h01F8, 32'h01F4, 1'b0};
        // LDMDB r5!,{r0,r15} wrapping through zero
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0004, 16'h8001,
                    32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
        // STMIA r2!,{r2,r3}: stored base then written back
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0300, 16'h000C,
                    32'h0300, 32'h0308, 1'b1};
        // LDMIA r6,{r0} unaligned base passes through
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h1002, 16'h0001,
                    32'h1002, 32'h1006, 1'b0};

        for (int i = 0; i < 16; i++) regs[i] = 32'hA000 + 32'(i);
        regs[4]  = 32'd5;
        regs[14] = 32'd0;
        regs[2]  = 32'h0300;

        rst = 1'b1;
        start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
        base_idx = '0; base_addr = '0; reg_list = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_latch", 32'(latch_reg), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_widx", 32'(reg_widx), 32'd0);
        chk("rst_ridx", 32'(reg_ridx), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i, -1, 0);

        // Stall on the second word with a stray start during it.
        run_vec(vecs[0], 0, 1, 5);

        // Empty list: done right after start, nothing else.
        l0 = latch_total;
        start = 1'b1; is_load = 1'b1; wback = 1'b1; reg_list = 16'h0000;
        tick();
        start = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_req", 32'(mem_req), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        tick();
        chk("empty_idle", 32'(done), 32'd0);
        chk("empty_latch", 32'(latch_total - l0), 32'd0);

        // Back-to-back start straight out of DONE.
        run_vec(vecs[3], 3, -1, 0);

        // Reset during the third word of a 4-register load.
        r4 = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0400, 16'h00F0,
               32'h0400, 32'h0410, 1'b1};
        start = 1'b1; is_load = r4.ld; up = r4.up; pre = r4.pre;
        wback = r4.wb; base_idx = r4.bidx; base_addr = r4.base;
        reg_list = r4.list;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        #1;
        chk("w3_addr", mem_addr, 32'h0408);
        l0 = latch_total;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        mem_ack = 1'b1;
        #1;
        chk("abort_latch", 32'(latch_reg), 32'd0);
        tick();
        tick();
        mem_ack = 1'b0;
        chk("abort_cnt", 32'(latch_total - l0), 32'd0);

        run_vec(vecs[0], 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
